mem_dump_reader: RTL

//  Initiator on the DataMemory interface (master modport) that reads a contiguous

---
 rtl/mem_dump_reader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_dump_reader.sv
// Streams a contiguous range of data memory out on a valid/ready port, retrying dropped reads.
// Optional MEM_DUMP_CHECKSUM_EN appends a 32-bit running sum as one extra word after the data.
module mem_dump_reader #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_5000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [15:0] word_count,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  input  logic        mem_stall,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, SUM, FIN} state_t;
  logic [31:0] sum;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, FIN} state_t;
`endif

  state_t      state;
  logic [15:0] remaining;
  logic [31:0] next_addr;

  assign mem_we    = 1'b0;
  assign mem_wd    = '0;
  assign next_addr = (mem_addr == ADDR_LIMIT - 32'd1) ? '0 : mem_addr + 32'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      mem_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            mem_addr  <= (start_addr >= ADDR_LIMIT) ? '0 : start_addr;
            remaining <= word_count;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum       <= '0;
`endif
            if (word_count == 16'd0) begin
`ifdef MEM_DUMP_CHECKSUM_EN
              out_data  <= '0;
              out_valid <= 1'b1;
              state     <= SUM;
`else
              state     <= FIN;
`endif
            end else begin
              mem_en <= 1'b1;
              state  <= REQ;
            end
          end
        end
        REQ: state <= WAIT;
        // stall low in the cycle after en means the responder dropped the request
        WAIT: begin
          if (mem_stall) begin
            out_data  <= mem_rd;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            mem_en <= 1'b1;
            state  <= REQ;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - 16'd1;
            mem_addr  <= next_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum       <= sum + out_data;
`endif
            if (remaining > 16'd1) begin
              mem_en <= 1'b1;
              state  <= REQ;
            end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
              out_data  <= sum + out_data;
              out_valid <= 1'b1;
              state     <= SUM;
`else
              state     <= FIN;
`endif
            end
          end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        SUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= FIN;
          end
        end
`endif
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
